kgp_seq_ctrl: RTL and testbench

KGP_SEQ_CTRL -- requirements
Module: kgp_seq_ctrl

---
 rtl/kgp_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_kgp_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kgp_seq_ctrl.sv
// rtl/kgp_seq_ctrl.sv - multi-cycle instruction sequencer with memory handshake and timeout
module kgp_seq_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  instr_class,
  input  logic        cond_true,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        alu_go,
  output logic        reg_we,
  output logic        mem_to_reg,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR
  } state_t;

  localparam logic [2:0] ClsAlu    = 3'd0;
  localparam logic [2:0] ClsLoad   = 3'd1;
  localparam logic [2:0] ClsStore  = 3'd2;
  localparam logic [2:0] ClsBranch = 3'd3;
  localparam logic [2:0] ClsJump   = 3'd4;
  localparam logic [2:0] ClsHalt   = 3'd5;

  localparam int WaitW = $clog2(TIMEOUT + 2);

  state_t           state;
  state_t           nextState;
  logic [2:0]       classReg;
  logic [WaitW-1:0] waitCnt;
  logic             inAccess;
  logic             enterAccess;
  logic             timedOut;
  logic             retire;

  assign inAccess    = (state == FETCH) || (state == MEM);
  assign enterAccess = ((nextState == FETCH) || (nextState == MEM)) && (nextState != state);
  assign timedOut    = (waitCnt == WaitW'(TIMEOUT)) && !mem_ack;
  assign retire      = ((nextState == FETCH) &&
                        ((state == EXEC) || (state == MEM) || (state == WB))) ||
                       ((nextState == HALT) && (state != HALT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      classReg <= 3'd0;
    end else if (state == DECODE) begin
      classReg <= instr_class;
    end
  end

  // Counts unacknowledged request cycles of the current access only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitCnt <= '0;
    end else if (enterAccess) begin
      waitCnt <= '0;
    end else if (inAccess && !mem_ack) begin
      waitCnt <= waitCnt + WaitW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_count <= 16'd0;
    end else if (retire) begin
      instr_count <= instr_count + 16'd1;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start) nextState = FETCH;
      end
      FETCH: begin
        if (mem_ack)       nextState = DECODE;
        else if (timedOut) nextState = ERR;
      end
      DECODE: begin
        if (instr_class == ClsHalt)     nextState = HALT;
        else if (instr_class > ClsHalt) nextState = ERR;
        else                            nextState = EXEC;
      end
      EXEC: begin
        case (classReg)
          ClsAlu:             nextState = WB;
          ClsLoad, ClsStore:  nextState = MEM;
          default:            nextState = FETCH;
        endcase
      end
      MEM: begin
        if (mem_ack)       nextState = (classReg == ClsStore) ? FETCH : WB;
        else if (timedOut) nextState = ERR;
      end
      WB:      nextState = FETCH;
      HALT:    nextState = HALT;
      ERR:     nextState = ERR;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_sel    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    alu_go     = 1'b0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    err        = 1'b0;
    busy       = 1'b0;
    case (state)
      FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      DECODE: busy = 1'b1;
      EXEC: begin
        busy   = 1'b1;
        alu_go = 1'b1;
        if ((classReg == ClsJump) || ((classReg == ClsBranch) && cond_true)) begin
          pc_we  = 1'b1;
          pc_src = 1'b1;
        end
      end
      MEM: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (classReg == ClsStore);
      end
      WB: begin
        busy       = 1'b1;
        reg_we     = 1'b1;
        mem_to_reg = (classReg == ClsLoad);
      end
      HALT:    halted = 1'b1;
      ERR:     err    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_kgp_seq_ctrl.sv
// tb/tb_kgp_seq_ctrl.sv - self-checking bench for kgp_seq_ctrl
module tb_kgp_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  instr_class = 3'd0;
  logic        cond_true = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src;
  logic        alu_go, reg_we, mem_to_reg, busy, halted, err;
  logic [15:0] instr_count;
  logic [11:0] outs;

  int passCnt = 0;
  int totalCnt = 0;
  logic [15:0] modelCnt;

  localparam logic [2:0] A = 3'd0, L = 3'd1, S = 3'd2, B = 3'd3, J = 3'd4, H = 3'd5;
  localparam logic [11:0] PatFetchAck = 12'b1001_1000_0100;
  localparam logic [11:0] PatDecode   = 12'b0000_0000_0100;
  localparam logic [11:0] PatHalt     = 12'b0000_0000_0010;
  localparam logic [11:0] PatErr      = 12'b0000_0000_0001;

  kgp_seq_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .instr_class(instr_class),
    .cond_true(cond_true), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_sel(mem_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_go(alu_go), .reg_we(reg_we), .mem_to_reg(mem_to_reg), .busy(busy),
    .halted(halted), .err(err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign outs = {mem_req, mem_sel, mem_we, ir_we, pc_we, pc_src,
                 alu_go, reg_we, mem_to_reg, busy, halted, err};

  typedef struct {
    logic        rstN;
    logic        st;
    logic [2:0]  cls;
    logic        cond;
    logic        ack;
    logic [11:0] exp;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic startPulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Instruction-level model: cost and strobe counts follow from class and ack delays.
  task automatic runInstr(input logic [2:0] cls, input logic cond, input int fw, input int mw);
    int cycles, irN, aluN, pcN, regN, m2rN, weN, reqCnt, expCycles;
    bit done;
    cycles = 0; irN = 0; aluN = 0; pcN = 0; regN = 0; m2rN = 0; weN = 0; reqCnt = 0;
    done = 0;
    instr_class = cls;
    cond_true = cond;
    while (!done && cycles < 60) begin
      cycles++;
      if (mem_req) begin
        mem_ack = (reqCnt == (mem_sel ? mw : fw));
        reqCnt  = mem_ack ? 0 : reqCnt + 1;
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      #1;
      irN  += int'(ir_we);
      aluN += int'(alu_go);
      pcN  += int'(pc_we);
      regN += int'(reg_we);
      m2rN += int'(mem_to_reg);
      weN  += int'(mem_we);
      @(posedge clk);
      #1;
      if (instr_count != modelCnt) done = 1;
      @(negedge clk);
    end
    expCycles = fw + 3;
    case (cls)
      A: expCycles += 1;
      L: expCycles += mw + 2;
      S: expCycles += mw + 1;
      default: ;
    endcase
    modelCnt = modelCnt + 16'd1;
    check("rnd_cycles", cycles, expCycles);
    check("rnd_ir_we", irN, 1);
    check("rnd_alu_go", aluN, 1);
    check("rnd_pc_we", pcN, 1 + int'(cls == J || (cls == B && cond)));
    check("rnd_reg_we", regN, int'(cls == A || cls == L));
    check("rnd_mem_to_reg", m2rN, int'(cls == L));
    check("rnd_mem_we", weN, (cls == S) ? mw + 1 : 0);
    check("rnd_count", instr_count, modelCnt);
  endtask

  initial begin
    int n;
    bit reached;

    tbl[0]  = '{0, 0, A, 0, 0, 12'b0000_0000_0000, 0};
    tbl[1]  = '{1, 0, A, 0, 0, 12'b0000_0000_0000, 0};
    tbl[2]  = '{1, 1, A, 0, 0, 12'b0000_0000_0000, 0};
    tbl[3]  = '{1, 0, A, 0, 1, PatFetchAck, 0};
    tbl[4]  = '{1, 1, A, 0, 0, PatDecode, 0};
    tbl[5]  = '{1, 0, A, 0, 1, 12'b0000_0010_0100, 0};
    tbl[6]  = '{1, 0, A, 0, 0, 12'b0000_0001_0100, 0};
    tbl[7]  = '{1, 0, L, 0, 1, PatFetchAck, 1};
    tbl[8]  = '{1, 0, L, 0, 0, PatDecode, 1};
    tbl[9]  = '{1, 0, L, 0, 0, 12'b0000_0010_0100, 1};
    tbl[10] = '{1, 0, L, 0, 0, 12'b1100_0000_0100, 1};
    tbl[11] = '{1, 0, L, 0, 0, 12'b1100_0000_0100, 1};
    tbl[12] = '{1, 0, L, 0, 0, 12'b1100_0000_0100, 1};
    tbl[13] = '{1, 0, L, 0, 1, 12'b1100_0000_0100, 1};
    tbl[14] = '{1, 0, L, 0, 0, 12'b0000_0001_1100, 1};
    tbl[15] = '{1, 0, B, 0, 1, PatFetchAck, 2};
    tbl[16] = '{1, 0, B, 0, 0, PatDecode, 2};
    tbl[17] = '{1, 0, B, 0, 0, 12'b0000_0010_0100, 2};
    tbl[18] = '{1, 0, B, 1, 1, PatFetchAck, 3};
    tbl[19] = '{1, 0, B, 1, 0, PatDecode, 3};
    tbl[20] = '{1, 0, B, 1, 0, 12'b0000_1110_0100, 3};
    tbl[21] = '{1, 0, S, 0, 0, 12'b1000_0000_0100, 4};
    tbl[22] = '{1, 0, S, 0, 1, PatFetchAck, 4};
    tbl[23] = '{1, 0, S, 0, 0, PatDecode, 4};
    tbl[24] = '{1, 0, S, 0, 0, 12'b0000_0010_0100, 4};
    tbl[25] = '{1, 0, S, 0, 1, 12'b1110_0000_0100, 4};
    tbl[26] = '{1, 0, S, 0, 0, 12'b1000_0000_0100, 5};

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      rst = tbl[i].rstN; start = tbl[i].st; instr_class = tbl[i].cls;
      cond_true = tbl[i].cond; mem_ack = tbl[i].ack;
      #1;
      check($sformatf("vec%0d_outs", i), outs, tbl[i].exp);
      check($sformatf("vec%0d_count", i), instr_count, tbl[i].cnt);
    end

    doReset();
    startPulse();
    modelCnt = 16'd0;
    for (int k = 0; k < 40; k++) begin
      runInstr(3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 5), $urandom_range(0, 5));
    end
    instr_class = 3'd6 + 3'($urandom_range(0, 1));
    mem_ack = 1'b1;
    @(negedge clk) mem_ack = 1'b0;
    @(negedge clk);
    check("illegal_err", outs, PatErr);
    check("illegal_count", instr_count, modelCnt);

    doReset();
    startPulse();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (err) break;
      if (mem_req) n++;
      @(negedge clk);
    end
    check("timeout_req_cycles", n, 16);
    check("timeout_outs", outs, PatErr);

    doReset();
    startPulse();
    instr_class = A;
    repeat (15) @(negedge clk);
    mem_ack = 1'b1;
    #1;
    check("late_ack_outs", outs, PatFetchAck);
    @(negedge clk) mem_ack = 1'b0;
    check("late_ack_decode", outs, PatDecode);
    @(negedge clk);
    check("late_ack_exec", alu_go, 1);

    doReset();
    startPulse();
    instr_class = H; mem_ack = 1'b1;
    @(negedge clk) mem_ack = 1'b0;
    @(negedge clk);
    check("halt_outs", outs, PatHalt);
    check("halt_count", instr_count, 1);
    repeat (4) begin
      start = 1'b1; mem_ack = 1'b1;
      @(negedge clk);
    end
    start = 1'b0; mem_ack = 1'b0;
    check("halt_sticky_outs", outs, PatHalt);
    check("halt_sticky_count", instr_count, 1);

    doReset();
    startPulse();
    instr_class = L; mem_ack = 1'b1;
    @(negedge clk) mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midmem_req", {mem_req, mem_sel, mem_we}, 3'b110);
    #2 rst = 1'b0;
    #1;
    check("midmem_reset_outs", outs, 0);
    check("midmem_reset_count", instr_count, 0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", outs, 0);

    startPulse();
    instr_class = J; mem_ack = 1'b1;
    reached = 0;
    for (int c = 0; c < 200000; c++) begin
      @(negedge clk);
      if (instr_count == 16'hFFFF) begin
        reached = 1;
        break;
      end
    end
    check("wrap_reach_ffff", {15'd0, reached}, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (instr_count != 16'hFFFF) break;
    end
    check("wrap_to_zero", instr_count, 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
